dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the pipelined RV32I core: the target end of the core's load/store port.
//  Accepts one load/store request at a time via valid/ready handshake, inserts programmable wait states,
//  performs byte/half/word lane steering and sign/zero extension per RV32I funct3, returns response + error.
//  Sits between the core's memory stage (stall logic drives on req_ready/rsp_valid) and on-chip word SRAM.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words in the array; valid byte addresses 0 .. 4*DEPTH_WORDS-1
//  WAIT_CYCLES  1     wait states between acceptance and response (0 allowed)
// PORTS
//  clk         in   1   single clock, all state updates on rising edge
//  reset       in   1   synchronous, active-low reset
//  req_valid   in   1   request present
//  req_ready   out  1   responder can accept (high only in IDLE)
//  req_we      in   1   1=store, 0=load
//  req_funct3  in   3   RV32I funct3 of the load/store (size + signedness)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, unaligned-LSB form (byte in [7:0], half in [15:0])
//  rsp_valid   out  1   response present
//  rsp_ready   in   1   requester accepts response
//  rsp_rdata   out  32  load result, extended; 0 for stores and errors
//  rsp_err     out  1   misaligned, out-of-range or illegal funct3
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE, wait counter=0, req_ready=1 after reset release, rsp_valid=0,
//   rsp_rdata=0, rsp_err=0. SRAM contents NOT cleared. Reset mid-operation aborts; uncommitted store dropped.
//  FSM IDLE -> (req_valid&req_ready) latch we/funct3/addr/wdata -> WAIT (or RESP directly if WAIT_CYCLES==0).
//   WAIT: counter counts 0..WAIT_CYCLES-1, then -> RESP. RESP: rsp_valid=1, outputs stable until
//   rsp_ready=1, then -> IDLE. req_ready=0 in WAIT and RESP; requests there are ignored, not queued.
//  Latency: accept at edge N -> rsp_valid high from cycle N+1+WAIT_CYCLES. Back-to-back: next request
//   accepted the cycle after the response handshake (req_ready combinational on state==IDLE).
//  Loads funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
//  Lane select by addr[1:0]; LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend.
//  Stores: byte-enable mask from size+addr[1:0]; wdata replicated to lanes; write of masked lanes only.
//  Store commit: single write on the edge entering RESP, only if rsp_err will be 0.
//  Load read: word sampled on the edge entering RESP (sync-read SRAM), steered into rsp_rdata.
//  Errors (rsp_err=1, rsp_rdata=0, no write): half with addr[0]=1; word with addr[1:0]!=0;
//   addr[31:2] >= DEPTH_WORDS; funct3 outside the legal set for the direction (e.g. store 100).
//  Error still takes full latency and handshake; FSM never hangs.
//  rsp_valid held with rsp_ready=0: no output change, no second write.
// STRUCTURE
//  Package rv_mem_pkg: funct3 localparams (F3_B,F3_H,F3_W,F3_BU,F3_HU), state enum {IDLE,WAIT,RESP},
//   byte-enable function be_of(funct3,addr_lo).
//  Sub-module mem_lane_align (combinational): store lane replicate + mask, load lane extract + extend.
//  Top holds FSM, wait counter, request latch, SRAM array (reg [31:0] mem[DEPTH_WORDS]).
// TESTING
//  SW 0xDEADBEEF @0x10, then LW @0x10, WAIT_CYCLES=1 -> rsp_valid 2 cycles after accept, rdata=0xDEADBEEF.
//  SB 0x80 @0x11 over 0xDEADBEEF -> LW @0x10 =0xDEAD80EF; LB @0x11 =0xFFFFFF80; LBU @0x11 =0x00000080.
//  SH 0x8001 @0x12, LH @0x12 =0xFFFF8001, LHU =0x00008001; LH @0x13 -> rsp_err=1, rdata=0.
//  SW 0x12345678 @0x16 (misaligned) -> rsp_err=1, LW @0x14 unchanged; LW @4*DEPTH_WORDS -> rsp_err=1.
//  rsp_ready held 0 for 5 cycles on a store -> rsp_valid/rdata stable, req_ready=0, exactly one write.
//  reset=0 asserted during WAIT of SW @0x20 -> IDLE next cycle, rsp_valid=0, LW @0x20 returns old value;
//   WAIT_CYCLES=0 build: back-to-back LW accepted every 2 cycles with rsp_ready tied 1.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states
// and the store byte-enable helper.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    function automatic logic [3:0] be_of(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = 4'b0011 << addr_lo;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        if (we)
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the core's LSB-aligned data and the 32-bit SRAM word:
// store replication + byte enables, load extraction + sign/zero extension.
module mem_lane_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [31:0] st_lanes,
    output logic [3:0]  st_be,
    output logic [31:0] ld_data
);
    logic [31:0] shifted;

    always_comb begin
        st_be = be_of(funct3, addr_lo);
        case (funct3[1:0])
            2'b00:   st_lanes = {4{st_data[7:0]}};
            2'b01:   st_lanes = {2{st_data[15:0]}};
            default: st_lanes = st_data;
        endcase

        shifted = ld_word >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data = {24'h000000, shifted[7:0]};
            F3_HU:   ld_data = {16'h0000, shifted[15:0]};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Target end of the core's load/store port: one request at a time, programmable
// wait states, lane steering, error detection, backed by a sync-read word SRAM.
module dmem_responder
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rd_word_q;

    logic          idle;
    logic          cur_we, cur_err, misaligned, out_of_range, enter_resp;
    logic [2:0]    cur_f3;
    logic [31:0]   cur_addr, cur_wdata;
    logic [AW-1:0] idx;
    logic [31:0]   st_lanes, ld_data;
    logic [3:0]    st_be;
    logic          mem_wr, mem_rd;

    // In IDLE the live request is used so a zero-wait build can commit on the accept edge.
    assign idle      = (state_q == IDLE);
    assign cur_we    = idle ? req_we     : we_q;
    assign cur_f3    = idle ? req_funct3 : f3_q;
    assign cur_addr  = idle ? req_addr   : addr_q;
    assign cur_wdata = idle ? req_wdata  : wdata_q;
    assign idx       = cur_addr[AW+1:2];

    assign misaligned   = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                          ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    assign out_of_range = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign cur_err      = misaligned || out_of_range || !f3_legal(cur_we, cur_f3);

    mem_lane_align u_align (
        .funct3   (cur_f3),
        .addr_lo  (cur_addr[1:0]),
        .st_data  (cur_wdata),
        .ld_word  (rd_word_q),
        .st_lanes (st_lanes),
        .st_be    (st_be),
        .ld_data  (ld_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        enter_resp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    if (WAIT_CYCLES == 0) enter_resp = 1'b1;
                    else                  state_d    = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) enter_resp = 1'b1;
                else                   cnt_d      = cnt_q + 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = cur_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Gating with reset drops a store whose commit edge coincides with reset.
    assign mem_wr = enter_resp && cur_we && !cur_err && reset;
    assign mem_rd = enter_resp && !cur_we && reset;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) mem[idx][8*i +: 8] <= st_lanes[8*i +: 8];
            end
        end
        if (mem_rd) rd_word_q <= mem[idx];
    end

    assign req_ready = idle;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = (rsp_valid_q && !rsp_err_q && !we_q) ? ld_data : 32'h0;

endmodule
